// File: rtl/mips_fetch.sv
// Instruction fetch front end: issues word-aligned memory requests under a
// credit limit and queues in-order responses with their PCs for the core.
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam logic [CW:0] LIMIT = DEPTH[CW:0];

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_pc_mem  [DEPTH];
    logic [31:0]   r_ins_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_stale;
    logic [CW-1:0] w_outst_nxt;
    logic [CW-1:0] w_stale_nxt;
    logic [CW:0]   w_credit;
    logic [31:0]   w_redir_pc;
    logic          w_req;
    logic          w_gnt;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic          w_unused_bits;

    assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
    assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

    // Buffered plus in-flight words may never exceed DEPTH, so a push always has room.
    assign w_credit = {1'b0, r_count} + {1'b0, r_outst};
    assign w_req    = rst && (r_state == S_RUN) && (w_credit < LIMIT);
    assign w_gnt    = w_req && imem_gnt;
    assign w_rsp    = imem_rvalid && (r_outst != '0);
    assign w_drop   = w_rsp && (r_stale != '0);
    assign w_push   = w_rsp && (r_stale == '0) && (r_state == S_RUN) && !redirect;
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && inst_ready && !redirect;

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_gnt && !w_rsp) begin
            w_outst_nxt = r_outst + CW'(1);
        end else if (!w_gnt && w_rsp) begin
            w_outst_nxt = r_outst - CW'(1);
        end
    end

    // A redirect marks everything still in flight (including this cycle's grant) as stale.
    always_comb begin
        w_stale_nxt = r_stale;
        w_state_nxt = r_state;
        if (redirect) begin
            w_stale_nxt = w_outst_nxt;
            w_state_nxt = (w_outst_nxt != '0) ? S_FLUSH : S_RUN;
        end else begin
            if (w_drop) begin
                w_stale_nxt = r_stale - CW'(1);
            end
            if ((r_state == S_FLUSH) && (w_stale_nxt == '0)) begin
                w_state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_stale    <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_outst <= w_outst_nxt;
            r_stale <= w_stale_nxt;
            if (redirect) begin
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_gnt) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= r_resp_pc;
            r_ins_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign inst_valid  = w_valid;
    assign instruction = w_valid ? r_ins_mem[r_rd_ptr] : '0;
    assign pc          = w_valid ? r_pc_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: in-order memory model with configurable
// latency, directed corner cases, a redirect vector table and a random run.
module tb_mips_fetch;

    localparam logic [31:0] RST_PC = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc;

    mips_fetch #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .pc(pc)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic        exp_req;
        logic        exp_valid;
    } vec_t;

    pend_t       pending[$];
    vec_t        vecs[5];
    int unsigned n_pass = 0, n_total = 0;
    int unsigned cyc = 0, last_due = 0, n_grants = 0, n_pops = 0;
    int unsigned lat_min = 1, lat_max = 1, gnt_pct = 100;
    bit          mem_on = 1'b0, after_redir = 1'b0;
    logic [31:0] exp_fetch = RST_PC, exp_pc = RST_PC;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: wait expired, got no event expected event (t=%0t)", name, $time);
    endtask

    // End-of-cycle bookkeeping: grants go to the memory queue, pops are checked
    // against a consecutive PC stream starting at the last redirect target.
    task automatic observe();
        pend_t       e;
        int unsigned lat;
        if (!rst) begin
            exp_fetch   = RST_PC;
            exp_pc      = RST_PC;
            after_redir = 1'b0;
        end else begin
            if (imem_req && imem_gnt) begin
                chk("grant_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                lat   = lat_min + $urandom_range(lat_max - lat_min);
                e.addr = imem_addr;
                e.due  = cyc + lat;
                if (e.due <= last_due) e.due = last_due + 1;
                last_due = e.due;
                pending.push_back(e);
                n_grants++;
            end
            if (inst_valid && inst_ready && !redirect) begin
                chk("pop_pc", pc, exp_pc);
                chk("pop_instr", instruction, memword(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_pops++;
            end
            if (redirect) begin
                exp_fetch   = redirect_pc & 32'hFFFF_FFFC;
                exp_pc      = redirect_pc & 32'hFFFF_FFFC;
                after_redir = 1'b1;
            end
        end
    endtask

    task automatic mem_drive();
        cyc++;
        if (pending.size() != 0 && pending[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = mem_on && ($urandom_range(99) < gnt_pct);
    endtask

    task automatic step();
        #1;
        observe();
        @(posedge clk);
        #1;
        redirect = 1'b0;
        mem_drive();
        if (after_redir) begin
            chk("valid_after_redirect", 32'(inst_valid), 32'd0);
            after_redir = 1'b0;
        end
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
    endtask

    task automatic drain();
        bit done;
        done       = 1'b0;
        inst_ready = 1'b1;
        mem_on     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (pending.size() == 0 && !imem_rvalid && !inst_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("drain");
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    initial begin
        bit          ok;
        int unsigned g0, p0, lv;

        vecs[0] = '{32'h0000_0203, 32'h0000_0200, 1'b1, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1, 1'b0};
        vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0006, 32'h8000_0004, 1'b1, 1'b0};

        // Reset values
        #2 rst = 1'b0;
        mem_on     = 1'b1;
        inst_ready = 1'b1;
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pc", pc, 32'd0);

        // Release: request immediately, first pc two cycles after the first grant
        rst = 1'b1;
        #1;
        chk("req_after_release", 32'(imem_req), 32'd1);
        step();
        chk("lat_valid_n1", 32'(inst_valid), 32'd0);
        step();
        chk("lat_valid_n2", 32'(inst_valid), 32'd1);
        chk("seq_pc0", pc, 32'h1000_0000);
        step();
        chk("seq_pc1", pc, 32'h1000_0004);
        step();
        chk("seq_pc2", pc, 32'h1000_0008);

        // Redirect vector table from idle
        drain();
        for (int i = 0; i < 5; i++) begin
            do_redirect(vecs[i].rpc);
            step();
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
        end

        // Backpressure: credit limit of four
        inst_ready = 1'b0;
        mem_on     = 1'b1;
        g0 = n_grants;
        repeat (15) step();
        chk("bp_grants", n_grants - g0, 32'd4);
        chk("bp_req_off", 32'(imem_req), 32'd0);
        chk("bp_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        step();
        chk("bp_resume", 32'(imem_req), 32'd1);

        // Redirect with two requests outstanding
        drain();
        lat_min = 6;
        lat_max = 6;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b1;
        step();
        do_redirect(32'h0000_0203);
        step();
        chk("flush_req", 32'(imem_req), 32'd0);
        lat_min = 1;
        lat_max = 1;
        mem_on  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("flush_resume");
        else begin
            chk("flush_drops_done", 32'(pending.size()), 32'd0);
            chk("flush_addr", imem_addr, 32'h0000_0200);
        end
        wait_valid("flush_deliver", ok);
        if (ok) begin
            chk("flush_pc", pc, 32'h0000_0200);
            chk("flush_instr", instruction, memword(32'h0000_0200));
        end

        // Redirect coinciding with a grant and a pop
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_req && imem_gnt && inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("gp_setup");
        do_redirect(32'h0000_4000);
        step();
        chk("gp_valid", 32'(inst_valid), 32'd0);
        chk("gp_req", 32'(imem_req), 32'd0);
        wait_valid("gp_deliver", ok);
        if (ok) chk("gp_pc", pc, 32'h0000_4000);

        // Fetch address wrap
        drain();
        do_redirect(32'hFFFF_FFFC);
        mem_on = 1'b1;
        step();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req", 32'(imem_req), 32'd1);
        step();
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        if (!inst_valid) wait_valid("wrap_deliver", ok);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);

        // Reset mid-burst with three outstanding
        drain();
        inst_ready = 1'b0;
        imem_gnt   = 1'b1;
        step();
        lat_min = 6;
        lat_max = 6;
        repeat (3) begin
            imem_gnt = 1'b1;
            step();
        end
        chk("mr_pre_valid", 32'(inst_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", imem_addr, RST_PC);
        chk("mr_valid", 32'(inst_valid), 32'd0);
        chk("mr_instr", instruction, 32'd0);
        chk("mr_pc", pc, 32'd0);
        step();
        step();
        rst        = 1'b1;
        inst_ready = 1'b1;
        lv = 0;
        repeat (10) begin
            step();
            if (inst_valid) lv++;
        end
        chk("mr_late_ignored", lv, 32'd0);
        chk("mr_addr_after", imem_addr, RST_PC);

        // Randomized traffic against the stream model
        drain();
        lat_min = 1;
        lat_max = 4;
        gnt_pct = 60;
        mem_on  = 1'b1;
        p0 = n_pops;
        for (int i = 0; i < 3000; i++) begin
            inst_ready = ($urandom_range(3) != 0);
            if ($urandom_range(99) < 3) begin
                if ($urandom_range(3) == 0) do_redirect(32'hFFFF_FFF0 | 32'($urandom_range(15)));
                else do_redirect($urandom);
            end
            step();
        end
        chk("random_progress", 32'(n_pops - p0 > 300), 32'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
